// File: rtl/frame_sequencer.sv
// Frame sequencer: walks each frame through matrix setup, render and drain, then
// holds the finished frame until the next display swap slot boundary.
module frame_sequencer #(
    parameter int unsigned FRAME_PERIOD = 2_000_000,
    parameter int unsigned IDLE_CYCLES  = 64
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        framebuffer_ready_in,
    input  logic        matrix_valid_in,
    input  logic        fetch_done_in,
    input  logic        pixel_valid_in,
    output logic        matrix_start_out,
    output logic        fetch_rst_out,
    output logic        framebuffer_switch_out,
    output logic        framebuffer_clear_out,
    output logic        busy_out,
    output logic [15:0] frame_count_out,
    output logic [15:0] pixel_count_out,
    output logic [15:0] overrun_count_out,
    output logic [2:0]  state_out
);

    localparam int TIMER_W = (FRAME_PERIOD > 2) ? $clog2(FRAME_PERIOD) : 1;
    localparam int IDLE_W  = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FRAME_PERIOD - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(IDLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_MATRIX = 3'd1,
        S_RENDER      = 3'd2,
        S_DRAIN       = 3'd3,
        S_WAIT_SWAP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                rst_meta;
    logic                rst_sync_n;
    logic [TIMER_W-1:0]  timer;
    logic                tick;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [15:0]         live_cnt;
    logic                start_frame;
    logic                drain_done;
    logic                start_hit;
    logic                swap_hit;
    logic                overrun_hit;

    // Assertion reaches every flop at once; release is retimed through two stages.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_meta   <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta   <= 1'b1;
            rst_sync_n <= rst_meta;
        end
    end

    assign tick        = (timer == TIMER_LAST);
    assign start_frame = enable_in && framebuffer_ready_in && !framebuffer_switch_out;
    assign drain_done  = (state == S_DRAIN) && !pixel_valid_in && (idle_cnt == IDLE_LAST);
    assign state_out   = state;

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            timer <= '0;
        end else if (tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:        if (start_frame)     state_nxt = S_WAIT_MATRIX;
            S_WAIT_MATRIX: if (matrix_valid_in) state_nxt = S_RENDER;
            S_RENDER:      if (fetch_done_in)   state_nxt = S_DRAIN;
            S_DRAIN:       if (drain_done)      state_nxt = S_WAIT_SWAP;
            S_WAIT_SWAP:   if (tick)            state_nxt = S_IDLE;
            default:                            state_nxt = S_IDLE;
        endcase
    end

    // A slot boundary that finds a frame still in flight is a missed slot.
    always_comb begin
        start_hit     = 1'b0;
        swap_hit      = 1'b0;
        overrun_hit   = 1'b0;
        fetch_rst_out = 1'b1;
        busy_out      = 1'b0;
        case (state)
            S_IDLE: begin
                start_hit = start_frame;
            end
            S_WAIT_MATRIX: begin
                busy_out    = 1'b1;
                overrun_hit = tick;
            end
            S_RENDER, S_DRAIN: begin
                busy_out      = 1'b1;
                fetch_rst_out = 1'b0;
                overrun_hit   = tick;
            end
            S_WAIT_SWAP: begin
                swap_hit = tick;
            end
            default: begin
                busy_out = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            matrix_start_out       <= 1'b0;
            framebuffer_switch_out <= 1'b0;
            framebuffer_clear_out  <= 1'b0;
        end else begin
            matrix_start_out       <= start_hit;
            framebuffer_switch_out <= swap_hit;
            framebuffer_clear_out  <= swap_hit;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            idle_cnt <= '0;
        end else if ((state != S_DRAIN) || pixel_valid_in) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            live_cnt <= '0;
        end else if ((state == S_WAIT_MATRIX) && matrix_valid_in) begin
            live_cnt <= '0;
        end else if (((state == S_RENDER) || (state == S_DRAIN)) && pixel_valid_in
                     && (live_cnt != 16'hFFFF)) begin
            live_cnt <= live_cnt + 1'b1;
        end
    end

    // The last drain cycle is pixel-free, so live_cnt is already final here.
    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            pixel_count_out <= '0;
            frame_count_out <= '0;
        end else if (drain_done) begin
            pixel_count_out <= live_cnt;
            frame_count_out <= frame_count_out + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            overrun_count_out <= '0;
        end else if (overrun_hit && (overrun_count_out != 16'hFFFF)) begin
            overrun_count_out <= overrun_count_out + 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: a frame-level driver plans each frame, a slot-arithmetic
// model predicts start/swap events, and a monitor compares them as they appear.
module tb_frame_sequencer;

  localparam int P  = 100;
  localparam int IC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic ready = 1'b0;
  logic mvalid = 1'b0;
  logic fdone = 1'b0;
  logic pixel = 1'b0;
  logic matrix_start, fetch_rst, fb_switch, fb_clear, busy;
  logic [15:0] frame_count, pixel_count, overrun_count;
  logic [2:0] state_dbg;

  frame_sequencer #(.FRAME_PERIOD(P), .IDLE_CYCLES(IC)) dut (
    .clk_in                (clk),
    .rst_n_in              (rst_n),
    .enable_in             (enable),
    .framebuffer_ready_in  (ready),
    .matrix_valid_in       (mvalid),
    .fetch_done_in         (fdone),
    .pixel_valid_in        (pixel),
    .matrix_start_out      (matrix_start),
    .fetch_rst_out         (fetch_rst),
    .framebuffer_switch_out(fb_switch),
    .framebuffer_clear_out (fb_clear),
    .busy_out              (busy),
    .frame_count_out       (frame_count),
    .pixel_count_out       (pixel_count),
    .overrun_count_out     (overrun_count),
    .state_out             (state_dbg)
  );

  // clock / reset-relative cycle index
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // scoreboard
  typedef struct {
    int cyc;
    int pix;
    int frm;
    int ovr;
  } swap_t;

  int    start_q[$];
  swap_t swap_q[$];
  int    checks = 0;
  int    passed = 0;
  int    exp_frames = 0;
  int    exp_overruns = 0;
  int    sw_cycle = -100;
  bit    finished = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // After release, the slot timer reads 0 in cycle 2; a tick is timer == P-1.
  function automatic bit is_tick(input int t);
    return (t >= 2) && (((t - 2) % P) == (P - 1));
  endfunction

  function automatic int ticks_between(input int a, input int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (is_tick(t)) n++;
    return n;
  endfunction

  function automatic int next_tick(input int a);
    int t = a;
    while (!is_tick(t)) t++;
    return t;
  endfunction

  // monitor
  int    mon_start;
  swap_t mon_swap;
  always @(negedge clk) begin
    if (rst_n) begin
      if (fb_switch || fb_clear) check("clear_with_switch", int'(fb_clear), int'(fb_switch));
      if (matrix_start) begin
        if (start_q.size() == 0) begin
          check("unexpected_start", int'(matrix_start), 0);
        end else begin
          mon_start = start_q.pop_front();
          check("start_cycle", cyc, mon_start);
          check("start_busy", int'(busy), 1);
          check("start_fetch_rst", int'(fetch_rst), 1);
        end
      end
      if (fb_switch) begin
        if (swap_q.size() == 0) begin
          check("unexpected_switch", int'(fb_switch), 0);
        end else begin
          mon_swap = swap_q.pop_front();
          check("switch_cycle", cyc, mon_swap.cyc);
          check("pixel_count", int'(pixel_count), mon_swap.pix);
          check("frame_count", int'(frame_count), mon_swap.frm);
          check("overrun_count", int'(overrun_count), mon_swap.ovr);
          check("switch_busy", int'(busy), 0);
          check("switch_fetch_rst", int'(fetch_rst), 1);
        end
      end
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_until(input int n);
    while (cyc < n) begin
      enable = 1'b0;
      ready  = 1'b1;
      mvalid = 1'($urandom);
      fdone  = 1'($urandom);
      pixel  = 1'($urandom);
      next_cycle();
    end
  endtask

  task automatic busy_noise();
    enable = 1'($urandom);
    ready  = 1'($urandom);
    mvalid = 1'($urandom);
    fdone  = 1'($urandom);
  endtask

  task automatic drain_cycle(input bit p);
    busy_noise();
    pixel = p;
    next_cycle();
  endtask

  task automatic run_frame(input int gap, input int rdy_delay, input int d, input int rlen_in,
                           input int rprob, input int nchunk_in, input bit max_gap,
                           input bit force_tick);
    int c0, cs, rs, e, pix, rlen, nchunk, g;
    rlen   = rlen_in;
    nchunk = force_tick ? 0 : nchunk_in;
    c0 = ((sw_cycle > cyc) ? sw_cycle : cyc) + gap;
    if (c0 < 3) c0 = 3;
    idle_until(c0);
    // No start is allowed in the cycle the swap pulse is high.
    cs = c0 + rdy_delay;
    if (cs == sw_cycle) cs++;
    start_q.push_back(cs + 1);
    while (cyc <= cs) begin
      enable = 1'b1;
      ready  = (cyc >= c0 + rdy_delay);
      mvalid = 1'($urandom);
      fdone  = 1'($urandom);
      pixel  = 1'($urandom);
      next_cycle();
    end
    for (int i = 0; i <= d; i++) begin
      busy_noise();
      mvalid = (i == d);
      pixel  = 1'($urandom);
      next_cycle();
    end
    rs = cs + 2 + d;
    if (force_tick) rlen = next_tick(rs + IC) - IC - rs + 1;
    pix = 0;
    for (int i = 0; i < rlen; i++) begin
      if (i == 0) check("render_fetch_rst", int'(fetch_rst), 0);
      busy_noise();
      fdone = (i == rlen - 1);
      pixel = (int'($urandom_range(99, 0)) < rprob);
      if (pixel) pix++;
      next_cycle();
    end
    for (int k = 0; k < nchunk; k++) begin
      g = max_gap ? IC - 1 : int'($urandom_range(IC - 1, 0));
      repeat (g) drain_cycle(1'b0);
      drain_cycle(1'b1);
      pix++;
    end
    repeat (IC) drain_cycle(1'b0);
    enable = 1'b0;
    e = rs + rlen - 1 + nchunk + IC;
    for (int k = 0; k < nchunk; k++) begin end
    e = cyc - 1;
    exp_frames   = (exp_frames + 1) % 65536;
    exp_overruns = exp_overruns + ticks_between(cs + 1, e);
    if (exp_overruns > 65535) exp_overruns = 65535;
    if (pix > 65535) pix = 65535;
    sw_cycle = next_tick(e + 1) + 1;
    swap_q.push_back('{sw_cycle, pix, exp_frames, exp_overruns});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_rst"}, int'(fetch_rst), 1);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_matrix_start"}, int'(matrix_start), 0);
    check({tag, "_switch"}, int'(fb_switch), 0);
    check({tag, "_clear"}, int'(fb_clear), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
    check({tag, "_pixel_count"}, int'(pixel_count), 0);
    check({tag, "_overrun_count"}, int'(overrun_count), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic finish_run();
    finished = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  initial begin
    #500000;
    if (!finished) begin
      checks++;
      $display("FAIL watchdog: got no completion, expected finish within 500000 time units");
      finish_run();
    end
  end

  int c0;
  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // nominal: matrix 3 cycles after start, exactly 10 pixels, clean drain
    run_frame(0, 0, 3, 10, 100, 0, 1'b0, 1'b0);
    // drain restarts: pixels land at idle count IC-1
    run_frame(0, 0, 1, 8, 50, 2, 1'b1, 1'b0);
    // long render spans several slot boundaries
    run_frame(1, 1, 2, 250, 30, 1, 1'b0, 1'b0);
    // drain completes exactly on a tick
    run_frame(2, 0, 0, 1, 40, 0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                int'($urandom_range(4, 0)), int'($urandom_range(60, 1)),
                int'($urandom_range(100, 0)), int'($urandom_range(3, 0)),
                1'($urandom), ($urandom_range(3, 0) == 0));
    end

    // enable held low in IDLE with the framebuffer ready
    idle_until(((sw_cycle > cyc) ? sw_cycle : cyc) + 300);
    check("gated_overrun_count", int'(overrun_count), exp_overruns);
    check("gated_frame_count", int'(frame_count), exp_frames);

    // reset dropped mid-render, between clock edges
    c0 = cyc + 2;
    idle_until(c0);
    enable = 1'b1;
    ready  = 1'b1;
    start_q.push_back(c0 + 1);
    next_cycle();
    enable = 1'b0;
    mvalid = 1'b1;
    next_cycle();
    mvalid = 1'b0;
    repeat (3) begin
      pixel = 1'b1;
      next_cycle();
    end
    check("abort_in_render", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    check("abort_pending_swaps", swap_q.size(), 0);
    start_q.delete();
    swap_q.delete();
    exp_frames   = 0;
    exp_overruns = 0;
    sw_cycle     = -100;
    pixel        = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();

    for (int i = 0; i < 2; i++) begin
      run_frame(int'($urandom_range(3, 0)), 0, int'($urandom_range(4, 0)),
                int'($urandom_range(40, 1)), int'($urandom_range(100, 0)),
                int'($urandom_range(2, 0)), 1'($urandom), 1'b0);
    end

    idle_until(sw_cycle + 3);
    check("pending_starts", start_q.size(), 0);
    check("pending_swaps", swap_q.size(), 0);
    finish_run();
  end

endmodule
